fifo_pixel_streamer: RTL and testbench

- Downstream consumer of the synchronous pixel FIFO.
- Drains the FIFO through its registered read port (rd_en/data_rd/empty).
- Presents the pixels as a valid/ready stream annotated with frame position: start-of-frame, end-of-line, end-of-frame.
- Feeds the next image-processing stage (line buffers / window generators) and absorbs that stage's backpressure without losing pixels.

---
 rtl/fifo_pixel_streamer.sv | 110 +++++++++++
 tb/tb_fifo_pixel_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pixel_streamer.sv
// fifo_pixel_streamer: drains a synchronous pixel FIFO through its registered
// read port into a 2-entry skid buffer and presents the pixels as a
// valid/ready stream tagged with start-of-frame / end-of-line / end-of-frame.
// Reads are issued only when the buffer is guaranteed room for the returning
// pixel, so downstream backpressure never loses data.
module fifo_pixel_streamer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [DATA_W-1:0] mem_q [2];
  logic              head_q;
  logic              tail_q;
  logic [1:0]        occ_q;
  logic              in_flight_q;
  logic              pop;
  logic [1:0]        level;

  // occ + in_flight never exceeds 2, and pop implies occ >= 1, so level
  // stays within 0..2 and doubles as the next occupancy.
  assign out_valid  = (occ_q != 2'd0);
  assign pop        = out_valid & out_ready;
  assign level      = occ_q + {1'b0, in_flight_q} - {1'b0, pop};
  assign fifo_rd_en = !flush && !fifo_empty && (level <= 2'd1);
  assign out_data   = mem_q[head_q];

  assign out_sof = out_valid && (col == '0) && (row == '0);
  assign out_eol = out_valid && (col == COL_LAST);
  assign out_eof = out_eol && (row == ROW_LAST);

  // Skid buffer: capture the returning FIFO word at the tail, retire at the head.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
    end else if (flush) begin
      // The in-flight word has already left the FIFO; it is simply not captured.
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
    end else begin
      if (in_flight_q) begin
        mem_q[tail_q] <= fifo_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      occ_q       <= level;
      in_flight_q <= fifo_rd_en;
    end
  end

  // Frame position of the pixel at the buffer head; advances per handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      col <= '0;
      row <= '0;
    end else if (flush) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // One-cycle pulse following the handshake of the last pixel of a frame.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_done <= 1'b0;
    end else if (flush) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & out_eof;
    end
  end

endmodule

// File: tb/tb_fifo_pixel_streamer.sv
// Directed bench for fifo_pixel_streamer with a small 4x2 frame and a
// behavioural synchronous FIFO (registered read port) feeding it.
module tb_fifo_pixel_streamer;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;

  logic              clk;
  logic              aresetn;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic              frame_done;
  logic [1:0]        col;
  logic [0:0]        row;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_pixel_streamer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .col        (col),
    .row        (row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: data_rd registered one cycle after rd_en; shares aresetn.
  logic [7:0] fmem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic push(input logic [7:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_checks++;
    if (col !== 2'd0 || row !== 1'b0) begin n_fail++; $display("FAIL reset_pos: got col=%0d row=%0d want 0/0", col, row); end
    n_checks++;
    if ({out_sof, out_eol, out_eof, frame_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {out_sof, out_eol, out_eof, frame_done});
    end
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
  endtask

  // Preloaded FIFO, downstream always ready: read from cycle 0, output from cycle 2, no gaps.
  task automatic test_stream();
    logic [7:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(8'(8'h10 + k));
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++;
      if (fifo_rd_en !== (c <= 7)) begin n_fail++; $display("FAIL stream_rd_en c=%0d: got %b want %b", c, fifo_rd_en, (c <= 7)); end
      n_checks++;
      if (out_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, out_valid, (c >= 2 && c <= 9)); end
      if (c >= 2 && c <= 9) begin
        exp_d = 8'(8'h10 + c - 2);
        n_checks++;
        if (out_data !== exp_d) begin n_fail++; $display("FAIL stream_data c=%0d: got %h want %h", c, out_data, exp_d); end
      end
      @(negedge clk);
    end
  endtask

  // 9 pixels over a 4x2 frame: flags, counters, frame_done, and wrap to the next frame.
  task automatic test_position();
    int k;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
    for (int c = 0; c < 13; c++) begin
      #1;
      k = c - 2;
      n_checks++;
      if (frame_done !== (c == 10)) begin n_fail++; $display("FAIL pos_frame_done c=%0d: got %b want %b", c, frame_done, (c == 10)); end
      if (k >= 0 && k <= 8) begin
        n_checks++;
        if (out_sof !== (k == 0 || k == 8)) begin n_fail++; $display("FAIL pos_sof k=%0d: got %b want %b", k, out_sof, (k == 0 || k == 8)); end
        n_checks++;
        if (out_eol !== (k % 4 == 3)) begin n_fail++; $display("FAIL pos_eol k=%0d: got %b want %b", k, out_eol, (k % 4 == 3)); end
        n_checks++;
        if (out_eof !== (k == 7)) begin n_fail++; $display("FAIL pos_eof k=%0d: got %b want %b", k, out_eof, (k == 7)); end
        n_checks++;
        if (col !== 2'(k % 4) || row !== 1'((k / 4) % 2)) begin
          n_fail++; $display("FAIL pos_colrow k=%0d: got %0d/%0d want %0d/%0d", k, col, row, k % 4, (k / 4) % 2);
        end
      end else begin
        n_checks++;
        if ({out_sof, out_eol, out_eof} !== 3'b000) begin n_fail++; $display("FAIL pos_idle_flags c=%0d: got %b want 000", c, {out_sof, out_eol, out_eof}); end
      end
      @(negedge clk);
    end
  endtask

  // Downstream stalls 5 cycles mid-stream: head held, reads stop, nothing lost or repeated.
  task automatic test_backpressure();
    int nexp;
    logic [7:0] exp_d;
    nexp = 0;
    do_reset();
    for (int i = 0; i < 12; i++) push(8'(8'h30 + i));
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      #1;
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en c=%0d: got %b want 0", c, fifo_rd_en); end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h32) begin
          n_fail++; $display("FAIL bp_hold c=%0d: got valid=%b data=%h want 1/32", c, out_valid, out_data);
        end
      end
      if (out_valid && out_ready) begin
        exp_d = 8'(8'h30 + nexp);
        n_checks++;
        if (out_data !== exp_d) begin n_fail++; $display("FAIL bp_seq n=%0d: got %h want %h", nexp, out_data, exp_d); end
        nexp++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (nexp !== 12) begin n_fail++; $display("FAIL bp_count: got %0d pixels want 12", nexp); end
  endtask

  // FIFO runs dry mid-stream, then a single refill pixel arrives 2 cycles after its read.
  task automatic test_drain();
    logic [7:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    push(8'h40); push(8'h41); push(8'h42);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if (fifo_rd_en && fifo_empty) begin n_fail++; $display("FAIL drain_underflow c=%0d: got rd_en=1 while empty want 0", c); end
      n_checks++;
      if (out_valid !== (c >= 2 && c <= 4)) begin n_fail++; $display("FAIL drain_valid c=%0d: got %b want %b", c, out_valid, (c >= 2 && c <= 4)); end
      if (c >= 2 && c <= 4) begin
        exp_d = 8'(8'h40 + c - 2);
        n_checks++;
        if (out_data !== exp_d) begin n_fail++; $display("FAIL drain_data c=%0d: got %h want %h", c, out_data, exp_d); end
      end
      @(negedge clk);
    end
    push(8'hA0);
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL refill_rd_en: got %b want 1", fifo_rd_en); end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL refill_early: got valid=%b want 0", out_valid); end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      n_fail++; $display("FAIL refill_data: got valid=%b data=%h want 1/a0", out_valid, out_data);
    end
  endtask

  // Flush at col=2,row=1 with one pixel buffered and one in flight (the fullest
  // state a pending read allows): both are dropped, counters clear.
  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    for (int c = 0; c < 8; c++) @(negedge clk);
    #1;
    n_checks++;
    if (col !== 2'd2 || row !== 1'b1 || out_data !== 8'h56) begin
      n_fail++; $display("FAIL flush_setup: got col=%0d row=%0d data=%h want 2/1/56", col, row, out_data);
    end
    flush = 1'b1;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || col !== 2'd0 || row !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got valid=%b col=%0d row=%0d want 0/0/0", out_valid, col, row);
    end
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL flush_resume_rd: got %b want 1", fifo_rd_en); end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale: got valid=%b data=%h want 0", out_valid, out_data); end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h58 || out_sof !== 1'b1) begin
      n_fail++; $display("FAIL flush_next: got valid=%b data=%h sof=%b want 1/58/1", out_valid, out_data, out_sof);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_data !== 8'h59 || col !== 2'd1 || out_sof !== 1'b0) begin
      n_fail++; $display("FAIL flush_follow: got data=%h col=%0d sof=%b want 59/1/0", out_data, col, out_sof);
    end
  endtask

  // Asynchronous reset between clock edges mid-frame, then a clean restart.
  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || col !== 2'd3 || out_eol !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup: got valid=%b col=%0d eol=%b want 1/3/1", out_valid, col, out_eol);
    end
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_eol !== 1'b0) begin
      n_fail++; $display("FAIL arst_out: got valid=%b data=%h eol=%b want 0/00/0", out_valid, out_data, out_eol);
    end
    n_checks++;
    if (col !== 2'd0 || row !== 1'b0 || frame_done !== 1'b0 || fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL arst_state: got col=%0d row=%0d fd=%b rd=%b want 0/0/0/0", col, row, frame_done, fifo_rd_en);
    end
    @(negedge clk);
    aresetn = 1'b1;
    push(8'h70); push(8'h71);
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_restart: got rd=%b valid=%b want 1/0", fifo_rd_en, out_valid);
    end
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h70 || out_sof !== 1'b1) begin
      n_fail++; $display("FAIL arst_first: got valid=%b data=%h sof=%b want 1/70/1", out_valid, out_data, out_sof);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_data !== 8'h71 || out_sof !== 1'b0 || col !== 2'd1) begin
      n_fail++; $display("FAIL arst_second: got data=%h sof=%b col=%0d want 71/0/1", out_data, out_sof, col);
    end
  endtask

  initial begin
    wr_ptr    = 8'd0;
    aresetn   = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_position();
    test_backpressure();
    test_drain();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
